// File: rtl/ethernet_arp_reply_transmitter.sv
// ============================================================================
// Module      : ethernet_arp_reply_transmitter
// Description : Builds an ARP reply frame for the local MAC/IP and streams it
//               as 64-bit AXI-Stream beats toward the 10G MAC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ethernet_arp_reply_transmitter #(
  parameter logic [47:0] FPGA_MAC   = 48'h211abcdef112,
  parameter logic [31:0] FPGA_IP    = 32'hC0000186,
  parameter bit          PAD_TO_MIN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [47:0] i_req_sha,
  input  logic [31:0] i_req_spa,
  output logic        o_tx_axis_tvalid,
  input  logic        i_tx_axis_tready,
  output logic [63:0] o_tx_axis_tdata,
  output logic        o_tx_axis_tlast,
  output logic [7:0]  o_tx_axis_tkeep,
  output logic        o_busy,
  output logic [15:0] o_frame_count
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  localparam logic [2:0] c_last_beat = PAD_TO_MIN ? 3'd7 : 3'd5;
  localparam logic [7:0] c_last_keep = PAD_TO_MIN ? 8'h0F : 8'h03;

  state_t        r_state;
  state_t        w_state_next;
  logic [335:0]  r_frame;
  logic [2:0]    r_beat;
  logic [15:0]   r_frame_count;
  logic [511:0]  w_frame_ext;
  logic          w_accept;
  logic          w_beat_done;
  logic          w_last;

  // Frame is stored lane-ordered: wire byte i lives at bits [8i+7:8i], so a
  // beat is simply a 64-bit slice. Bytes past 41 read as zero padding.
  function automatic logic [335:0] build_frame(input logic [47:0] sha,
                                               input logic [31:0] spa);
    logic [335:0] be;
    logic [335:0] le;
    be = {sha, FPGA_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
          16'h0002, FPGA_MAC, FPGA_IP, sha, spa};
    le = '0;
    for (int i = 0; i < 42; i++) begin
      le[8*i +: 8] = be[8*(41-i) +: 8];
    end
    return le;
  endfunction

  assign w_frame_ext = {176'd0, r_frame};
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_beat_done = o_tx_axis_tvalid && i_tx_axis_tready;
  assign w_last      = (r_beat == c_last_beat);
  assign o_frame_count = r_frame_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    o_req_ready      = 1'b0;
    o_busy           = 1'b0;
    o_tx_axis_tvalid = 1'b0;
    o_tx_axis_tdata  = 64'd0;
    o_tx_axis_tlast  = 1'b0;
    o_tx_axis_tkeep  = 8'h00;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (w_accept) begin
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        o_busy           = 1'b1;
        o_tx_axis_tvalid = 1'b1;
        o_tx_axis_tdata  = w_frame_ext[{r_beat, 6'd0} +: 64];
        o_tx_axis_tlast  = w_last;
        o_tx_axis_tkeep  = w_last ? c_last_keep : 8'hFF;
        if (i_tx_axis_tready && w_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_frame       <= '0;
      r_beat        <= 3'd0;
      r_frame_count <= 16'd0;
    end else if (w_accept) begin
      r_frame <= build_frame(i_req_sha, i_req_spa);
      r_beat  <= 3'd0;
    end else if (w_beat_done) begin
      if (w_last) begin
        r_beat        <= 3'd0;
        r_frame_count <= r_frame_count + 16'd1;
      end else begin
        r_beat <= r_beat + 3'd1;
      end
    end
  end

endmodule

`default_nettype wire
